ro_freq_counter: RTL and testbench

//  - Reader end of the ring-oscillator array: selects one RO output, counts its rising edges over a

---
 rtl/ro_meas_pkg.sv | 14 +
 rtl/ro_edge_sync.sv | 33 +++
 rtl/ro_freq_counter.sv | 136 +++++++++++++
 tb/tb_ro_freq_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and default widths for the ring-oscillator frequency counter.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        DONE
    } meas_state_t;

    localparam int CNT_W_DEF  = 24;
    localparam int GATE_W_DEF = 24;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizer chain for the selected RO output plus a rising-edge detector whose
// history flop only moves when primed or while counting.
module ro_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic prime,
    input  logic en,
    output logic rise
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [SYNC_STAGES-1:0] sync_p0;
    (* keep = "true" *) logic hist_p1;
    logic lvl;

    assign lvl  = sync_p0[SYNC_STAGES-1];
    assign rise = en & lvl & ~hist_p1;

    // Stage boundary: raw input -> synchronized level -> edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
            if (prime || en)
                hist_p1 <= lvl;
        end
    end

endmodule

// File: rtl/ro_freq_counter.sv
// Measures the rising-edge count of one selected RO channel over a gate window of clk
// cycles; the result is held with its channel and a saturation flag until the next done.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   ro_in,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  result,
    output logic [CH_W-1:0]   result_ch,
    output logic              overflow
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meas_state_t       state;
    logic [CH_W-1:0]   ch_lat;
    logic [GATE_W-1:0] gate_cnt;
    logic [ARM_W-1:0]  arm_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;

    logic              ro_mux;
    logic              prime;
    logic              counting;
    logic              rise;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_hit;
    logic              ovf_nxt;
    logic [CH_W-1:0]   ch_ok;

    // Returns {overflow_hit, next_count}; the count sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (!inc)
            return {1'b0, cnt};
        if (cnt == CNT_MAX)
            return {1'b1, cnt};
        return {1'b0, cnt + CNT_W'(1)};
    endfunction

    assign ch_ok    = (int'(ch_sel) < N_CH) ? ch_sel : '0;
    assign ro_mux   = ro_in[ch_lat];
    assign prime    = (state == ARM) && (arm_cnt == ARM_W'(SYNC_STAGES));
    assign counting = (state == COUNT);
    assign {ovf_hit, cnt_nxt} = sat_inc(edge_cnt, rise);
    assign ovf_nxt  = ovf_flag | ovf_hit;

    ro_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ro_mux),
        .prime(prime),
        .en   (counting),
        .rise (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_ch <= '0;
            overflow  <= 1'b0;
            ch_lat    <= '0;
            gate_cnt  <= '0;
            arm_cnt   <= '0;
            edge_cnt  <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= ARM;
                        busy     <= 1'b1;
                        ch_lat   <= ch_ok;
                        gate_cnt <= gate_cycles;
                        arm_cnt  <= '0;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                // ARM gives the synchronizer time to flush the previous channel's level.
                ARM: begin
                    if (prime) begin
                        if (gate_cnt == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            result    <= '0;
                            overflow  <= 1'b0;
                            result_ch <= ch_lat;
                        end else begin
                            state <= COUNT;
                        end
                    end else begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end
                end
                COUNT: begin
                    edge_cnt <= cnt_nxt;
                    ovf_flag <= ovf_nxt;
                    if (gate_cnt == GATE_W'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= cnt_nxt;
                        overflow  <= ovf_nxt;
                        result_ch <= ch_lat;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: square-wave RO models, a per-cycle edge-count model,
// and literal expectations for latency, counts, saturation and reset.
module tb_ro_freq_counter;

    localparam int N_CH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ro_in = '0;
    logic        start = 1'b0;
    logic [2:0]  ch_sel = '0;
    logic [23:0] gate_cycles = '0;

    logic        busy, done, overflow;
    logic [23:0] result;
    logic [2:0]  result_ch;
    logic        busy_s, done_s, overflow_s;
    logic [3:0]  result_s;
    logic [2:0]  result_ch_s;

    always #5 clk = ~clk;

    ro_freq_counter #(.N_CH(8), .CNT_W(24), .GATE_W(24), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .busy(busy), .done(done), .result(result),
        .result_ch(result_ch), .overflow(overflow)
    );

    ro_freq_counter #(.N_CH(8), .CNT_W(4), .GATE_W(24), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .busy(busy_s), .done(done_s), .result(result_s),
        .result_ch(result_ch_s), .overflow(overflow_s)
    );

    // RO channels: square wave of per[i] clk cycles, or static lvl[i] when per[i] is 0.
    int per [8];
    bit lvl [8];
    int rocnt = 0;
    always @(negedge clk) begin
        rocnt++;
        for (int i = 0; i < 8; i++)
            ro_in[i] = (per[i] == 0) ? lvl[i] : ((rocnt % per[i]) < (per[i] / 2));
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: a start seen at edge t while not busy opens a window; done follows G+3 edges
    // later with the count of 0->1 steps in the sampled channel over samples t+1..t+G+1.
    int cyc = 0;
    logic [7:0] hist [0:16383];
    bit m_act = 1'b0;
    int m_t = 0, m_g = 0, m_ch = 0;
    bit e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0, e_ovf_s = 1'b0;
    int e_res = 0, e_res_s = 0, e_ch = 0;

    always @(posedge clk) begin
        int n;
        cyc++;
        if (cyc < 16384)
            hist[cyc] = ro_in;
        if (rst) begin
            m_act = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_res = 0; e_res_s = 0; e_ovf = 1'b0; e_ovf_s = 1'b0; e_ch = 0;
        end else begin
            if (start && !(m_act && cyc >= m_t + 1 && cyc <= m_t + 3 + m_g)) begin
                m_act = 1'b1;
                m_t   = cyc;
                m_g   = int'(gate_cycles);
                m_ch  = (int'(ch_sel) < N_CH) ? int'(ch_sel) : 0;
            end
            e_busy = m_act && cyc >= m_t && cyc <= m_t + 2 + m_g;
            e_done = m_act && cyc == m_t + 3 + m_g;
            if (e_done) begin
                n = 0;
                for (int j = 1; j <= m_g; j++)
                    if (!hist[m_t + j][m_ch] && hist[m_t + j + 1][m_ch]) n++;
                e_res   = (n > 24'hFFFFFF) ? 24'hFFFFFF : n;
                e_ovf   = n > 24'hFFFFFF;
                e_res_s = (n > 15) ? 15 : n;
                e_ovf_s = n > 15;
                e_ch    = m_ch;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",        32'(busy),        32'(e_busy));
            chk("done",        32'(done),        32'(e_done));
            chk("result",      32'(result),      32'(e_res));
            chk("result_ch",   32'(result_ch),   32'(e_ch));
            chk("overflow",    32'(overflow),    32'(e_ovf));
            chk("sat_busy",    32'(busy_s),      32'(e_busy));
            chk("sat_done",    32'(done_s),      32'(e_done));
            chk("sat_result",  32'(result_s),    32'(e_res_s));
            chk("sat_overflow",32'(overflow_s),  32'(e_ovf_s));
        end
    end

    task automatic start_meas(input int ch, input int g, output int t);
        @(negedge clk);
        ch_sel      = ch[2:0];
        gate_cycles = g[23:0];
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t     = cyc;
    endtask

    task automatic wait_done(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc + 1;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", maxc);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"},     32'(busy),     32'd0);
        chk({nm, "_done"},     32'(done),     32'd0);
        chk({nm, "_result"},   32'(result),   32'd0);
        chk({nm, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int t, t2, at, nd;
        for (int i = 0; i < 8; i++) begin
            per[i] = 0;
            lvl[i] = 1'b0;
        end
        per[3] = 8;
        repeat (3) @(negedge clk);
        chk_idle("reset_init");
        chk("reset_init_ch", 32'(result_ch), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal measurement: period 8 over 800 cycles.
        start_meas(3, 800, t);
        wait_done(900, at);
        chk("nominal_latency", 32'(at), 32'(t + 804));
        chk("nominal_range", 32'(result >= 24'd99 && result <= 24'd101), 32'd1);
        chk("nominal_ch", 32'(result_ch), 32'd3);
        chk("nominal_ovf", 32'(overflow), 32'd0);
        chk("nominal_sat_res", 32'(result_s), 32'd15);
        chk("nominal_sat_ovf", 32'(overflow_s), 32'd1);

        // Reset while ARMed wipes the held result immediately.
        start_meas(3, 50, t);
        #2 rst = 1'b1;
        #1 chk_idle("reset_arm");
        @(negedge clk);
        rst = 1'b0;

        // Zero gate, then back-to-back start while done is high.
        start_meas(5, 0, t);
        wait_done(10, at);
        chk("zero_latency", 32'(at), 32'(t + 4));
        chk("zero_result", 32'(result), 32'd0);
        chk("zero_ch", 32'(result_ch), 32'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t2 = cyc;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(10, at);
        chk("b2b_latency", 32'(at), 32'(t2 + 4));

        // Saturation: period 4 over 100 cycles is 25 edges.
        per[2] = 4;
        start_meas(2, 100, t);
        wait_done(120, at);
        chk("sat_latency", 32'(at), 32'(t + 104));
        chk("sat_full_res", 32'(result), 32'd25);
        chk("sat_small_res", 32'(result_s), 32'd15);
        chk("sat_small_ovf", 32'(overflow_s), 32'd1);

        // Static channels and channel switches must not produce edges.
        per[0] = 0; lvl[0] = 1'b1;
        per[1] = 0; lvl[1] = 1'b1;
        per[2] = 0; lvl[2] = 1'b0;
        repeat (4) @(negedge clk);
        start_meas(1, 20, t);
        wait_done(40, at);
        chk("static_hi_res", 32'(result), 32'd0);
        start_meas(2, 20, t);
        wait_done(40, at);
        chk("switch_lo_res", 32'(result), 32'd0);
        start_meas(1, 20, t);
        wait_done(40, at);
        chk("switch_hi_res", 32'(result), 32'd0);
        start_meas(0, 20, t);
        wait_done(40, at);
        chk("ch0_static_res", 32'(result), 32'd0);
        chk("ch0_static_ch", 32'(result_ch), 32'd0);

        // Start pulses and input changes during COUNT are ignored.
        start_meas(3, 100, t);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; ch_sel = 3'd1; gate_cycles = 24'd5;
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
        end
        wait_done(150, at);
        chk("busy_start_latency", 32'(at), 32'(t + 104));
        chk("busy_start_range", 32'(result >= 24'd12 && result <= 24'd13), 32'd1);
        chk("busy_start_ch", 32'(result_ch), 32'd3);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("busy_start_single_done", 32'(nd), 32'd0);

        // Reset mid-COUNT, then a fresh nominal measurement.
        start_meas(3, 800, t);
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_idle("reset_count");
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("reset_count_no_done", 32'(nd), 32'd0);
        start_meas(3, 800, t);
        wait_done(900, at);
        chk("after_reset_latency", 32'(at), 32'(t + 804));
        chk("after_reset_range", 32'(result >= 24'd99 && result <= 24'd101), 32'd1);
        chk("after_reset_ch", 32'(result_ch), 32'd3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
